mips_regfile_write_arbiter: RTL and testbench

MIPS_REGFILE_WRITE_ARBITER -- requirements
Module: mips_regfile_write_arbiter

---
 rtl/mips_ctrl_pkg.sv | 15 +
 rtl/mips_rr_arb2.sv | 29 ++
 rtl/mips_regfile_write_arbiter.sv | 135 +++++++++++++
 tb/tb_mips_regfile_write_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the MIPS register-file write path:
// arbiter state and requester identifiers.
package mips_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage : mips_ctrl_pkg

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and a tie goes
// to whichever requester did not win last time.
module mips_rr_arb2
  import mips_ctrl_pkg::*;
(
  input  logic    a_valid,
  input  logic    b_valid,
  input  req_id_e last_grant,
  output logic    gnt_a,
  output logic    gnt_b
);

  // Grant selection; purely combinational so ready can answer in the same cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (a_valid && b_valid) begin
      if (last_grant == REQ_B) begin
        gnt_a = 1'b1;
      end else begin
        gnt_b = 1'b1;
      end
    end else begin
      gnt_a = a_valid;
      gnt_b = b_valid;
    end
  end

endmodule : mips_rr_arb2

// File: rtl/mips_regfile_write_arbiter.sv
// Merges ALU (A) and load (B) writeback into a single register-file write
// port, with a sequential zeroing pass after reset or on clear_req.
module mips_regfile_write_arbiter
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] CNT_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  req_id_e           last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic gnt_a_s;
  logic gnt_b_s;
  logic arb_open_s;

  mips_rr_arb2 u_rr_arb2 (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant_q),
    .gnt_a      (gnt_a_s),
    .gnt_b      (gnt_b_s)
  );

  // A clear request in ARB suppresses both grants for that cycle.
  assign arb_open_s = (state_q == ST_ARB) && !clear_req;
  assign a_ready    = arb_open_s && gnt_a_s;
  assign b_ready    = arb_open_s && gnt_b_s;

  assign signal_reg_write = we_q;
  assign write_reg        = wreg_q;
  assign write_data       = wdata_q;
  assign init_done        = (state_q == ST_ARB);

  // Next-state, clear counter and write-port computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_INIT: begin
        // clear_req is deliberately ignored here; the pass runs to completion.
        we_d    = 1'b1;
        wreg_d  = cnt_q;
        wdata_d = DATA_ZERO;
        if (cnt_q == CNT_MAX) begin
          state_d = ST_ARB;
          cnt_d   = REG_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ARB: begin
        if (clear_req) begin
          state_d = ST_INIT;
          cnt_d   = REG_ZERO;
        end else if (gnt_a_s) begin
          last_grant_d = REQ_A;
          // $zero is read-only: the handshake completes but no write is issued.
          if (a_reg != REG_ZERO) begin
            we_d    = 1'b1;
            wreg_d  = a_reg;
            wdata_d = a_data;
          end else begin
            we_d = 1'b0;
          end
        end else if (gnt_b_s) begin
          last_grant_d = REQ_B;
          if (b_reg != REG_ZERO) begin
            we_d    = 1'b1;
            wreg_d  = b_reg;
            wdata_d = b_data;
          end else begin
            we_d = 1'b0;
          end
        end else begin
          we_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = REG_ZERO;
      end
    endcase
  end

  // State and registered write-port flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_INIT : ST_ARB;
      cnt_q        <= REG_ZERO;
      last_grant_q <= REQ_B;
      we_q         <= 1'b0;
      wreg_q       <= REG_ZERO;
      wdata_q      <= DATA_ZERO;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule : mips_regfile_write_arbiter

// File: tb/tb_mips_regfile_write_arbiter.sv
// Scoreboard bench for mips_regfile_write_arbiter: expected writes are queued
// at handshake time and a negedge monitor checks them in order.
module tb_mips_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic        a_valid, a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        signal_reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        init_done;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  mips_regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .INIT_CLEAR(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear_req        (clear_req),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_reg            (a_reg),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_reg            (b_reg),
    .b_data           (b_data),
    .signal_reg_write (signal_reg_write),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .init_done        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issued write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && signal_reg_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write",
                 write_reg, write_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({write_reg, write_data} !== e) begin
          errors++;
          $display("FAIL write_order: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                   write_reg, write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic push_clear_pass();
    for (int r = 0; r < 32; r++) begin
      logic [4:0] rr;
      rr = r[4:0];
      exp_q.push_back({rr, 32'h0000_0000});
    end
  endtask

  // Called at posedge+1; asserts reset, checks outputs immediately, releases.
  task automatic do_reset();
    rst_n = 1'b0; clear_req = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #2;
    chk("rst_we",        {31'd0, signal_reg_write}, 32'd0);
    chk("rst_write_reg", {27'd0, write_reg},        32'd0);
    chk("rst_write_data", write_data,               32'd0);
    chk("rst_init_done", {31'd0, init_done},        32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_clear_pass();
  endtask

  // Runs n INIT cycles with requesters knocking for the first few.
  task automatic init_run(input int n);
    for (int k = 0; k < n; k++) begin
      a_valid = (k < 8); a_reg = 5'd3; a_data = 32'h33;
      b_valid = (k < 8); b_reg = 5'd4; b_data = 32'h44;
      #2;
      chk("init_a_ready",   {31'd0, a_ready},   32'd0);
      chk("init_b_ready",   {31'd0, b_ready},   32'd0);
      chk("init_done_low",  {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    if (n == 32) chk("init_done_high", {31'd0, init_done}, 32'd1);
  endtask

  // Called at posedge+1: applies one cycle of stimulus, checks readies, queues writes.
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic cr, input logic ea, input logic eb);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    clear_req = cr;
    #3;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
    if (av && ea && ar != 5'd0) exp_q.push_back({ar, ad});
    if (bv && eb && br != 5'd0) exp_q.push_back({br, bd});
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear_req = 1'b0;
    a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
    @(posedge clk); #1;
    do_reset();
    init_run(32);

    // Post-reset tie: A first, then alternate.
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b1, 1'b0);
    chk("tie1_we", {31'd0, signal_reg_write}, 32'd1);
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("idle_we",   {31'd0, signal_reg_write}, 32'd0);
    chk("idle_hold", {27'd0, write_reg},        32'd6);

    // $zero target: handshake completes, no write.
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("zero_reg_we", {31'd0, signal_reg_write}, 32'd0);

    // B alone.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    chk("b_only_we",   {31'd0, signal_reg_write}, 32'd1);
    chk("b_only_reg",  {27'd0, write_reg},        32'd31);
    chk("b_only_data", write_data,                32'hDEADBEEF);

    // Reset while a write is on the port, then reset again at cnt=10.
    do_reset();
    init_run(10);
    do_reset();
    init_run(32);

    // clear_req beats a simultaneous A request; a second clear mid-pass is ignored.
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    push_clear_pass();
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, (k == 4), 1'b0, 1'b0);
    end
    chk("clear_init_done", {31'd0, init_done}, 32'd1);
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mips_regfile_write_arbiter
